// File: rtl/partition_arbiter.sv
// Round-robin arbiter merging NUM_IN tuple streams into one registered output,
// with end-of-stream tracking and a saturating delivered-tuple counter.
module partition_arbiter #(
  parameter int          INPUT_SIZE  = 64,
  parameter int          NUM_IN      = 4,
  parameter logic [31:0] COUNT_RESET = 32'h0
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_IN-1:0]                   in_valid,
  output logic [NUM_IN-1:0]                   in_ready,
  input  logic [NUM_IN-1:0][INPUT_SIZE-1:0]   in_data,
  input  logic [NUM_IN-1:0][31:0]             in_tag,
  input  logic [NUM_IN-1:0][63:0]             in_serialnum,
  input  logic [NUM_IN-1:0]                   in_was_joined,
  input  logic [NUM_IN-1:0]                   in_last_processed,
  input  logic                                ready_4_output,
  output logic [INPUT_SIZE-1:0]               out_data,
  output logic [31:0]                         out_tag,
  output logic [63:0]                         out_serialnum,
  output logic                                out_was_joined,
  output logic                                out_valid,
  output logic                                out_last_processed,
  output logic [31:0]                         out_count
);

  localparam int PTR_W = $clog2(NUM_IN);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [NUM_IN-1:0]       done_q, done_d;
  logic [INPUT_SIZE-1:0]   out_data_q, out_data_d;
  logic [31:0]             out_tag_q, out_tag_d;
  logic [63:0]             out_serialnum_q, out_serialnum_d;
  logic                    out_was_joined_q, out_was_joined_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic [31:0]             out_count_q, out_count_d;

  logic                    ld;
  logic                    grant_found;
  logic [PTR_W-1:0]        grant_idx;
  logic [PTR_W:0]          scan_idx;
  logic                    all_done;
  logic                    any_valid;

  assign ld = ready_4_output | ~out_valid_q;

  // Scan streams starting at rr_ptr, wrapping modulo NUM_IN; first valid wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      scan_idx = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (scan_idx >= (PTR_W+1)'(NUM_IN)) begin
        scan_idx = scan_idx - (PTR_W+1)'(NUM_IN);
      end
      if (!grant_found && in_valid[scan_idx[PTR_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (ld && grant_found && !reset) begin
      in_ready = NUM_IN'(1) << grant_idx;
    end
  end

  always_comb begin
    out_data_d       = out_data_q;
    out_tag_d        = out_tag_q;
    out_serialnum_d  = out_serialnum_q;
    out_was_joined_d = out_was_joined_q;
    out_valid_d      = out_valid_q;
    rr_ptr_d         = rr_ptr_q;
    if (ld) begin
      if (grant_found) begin
        out_data_d       = in_data[grant_idx];
        out_tag_d        = in_tag[grant_idx];
        out_serialnum_d  = in_serialnum[grant_idx];
        out_was_joined_d = in_was_joined[grant_idx];
        out_valid_d      = 1'b1;
        rr_ptr_d         = (grant_idx == PTR_W'(NUM_IN - 1)) ? '0 : grant_idx + PTR_W'(1);
      end else begin
        out_data_d       = '0;
        out_tag_d        = '0;
        out_serialnum_d  = '0;
        out_was_joined_d = 1'b0;
        out_valid_d      = 1'b0;
      end
    end
  end

  always_comb begin
    out_count_d = out_count_q;
    if (out_valid_q && ready_4_output && (out_count_q != 32'hFFFF_FFFF)) begin
      out_count_d = out_count_q + 32'd1;
    end
  end

  // Done bits that set this cycle already count toward the all-done test.
  always_comb begin
    done_d    = done_q | (in_last_processed & ~in_valid);
    all_done  = &done_d;
    any_valid = |in_valid;
    state_d   = state_q;
    unique case (state_q)
      RUN: begin
        if (all_done && !any_valid) state_d = DRAIN;
      end
      DRAIN: begin
        if (any_valid) begin
          state_d = RUN;
        end else if (!out_valid_q || ready_4_output) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (any_valid) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    out_last_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= RUN;
      rr_ptr_q         <= '0;
      done_q           <= '0;
      out_data_q       <= '0;
      out_tag_q        <= '0;
      out_serialnum_q  <= '0;
      out_was_joined_q <= 1'b0;
      out_valid_q      <= 1'b0;
      out_last_q       <= 1'b0;
      out_count_q      <= COUNT_RESET;
    end else begin
      state_q          <= state_d;
      rr_ptr_q         <= rr_ptr_d;
      done_q           <= done_d;
      out_data_q       <= out_data_d;
      out_tag_q        <= out_tag_d;
      out_serialnum_q  <= out_serialnum_d;
      out_was_joined_q <= out_was_joined_d;
      out_valid_q      <= out_valid_d;
      out_last_q       <= out_last_d;
      out_count_q      <= out_count_d;
    end
  end

  assign out_data           = out_data_q;
  assign out_tag            = out_tag_q;
  assign out_serialnum      = out_serialnum_q;
  assign out_was_joined     = out_was_joined_q;
  assign out_valid          = out_valid_q;
  assign out_last_processed = out_last_q;
  assign out_count          = out_count_q;

endmodule

// File: tb/tb_partition_arbiter.sv
// Scoreboard bench for partition_arbiter: a behavioural model predicts grants,
// output tuples, end-of-stream state and the delivered count.
module tb_partition_arbiter;
  localparam int          INPUT_SIZE  = 64;
  localparam int          NUM_IN      = 4;
  localparam logic [31:0] SAT_PRELOAD = 32'hFFFF_FFFE;
  localparam int          P_RUN = 0, P_DRAIN = 1, P_DONE = 2;

  typedef struct packed {
    logic [INPUT_SIZE-1:0] data;
    logic [31:0]           tag;
    logic [63:0]           serial;
    logic                  joined;
  } tuple_t;

  logic                              clk = 1'b0;
  logic                              reset;
  logic [NUM_IN-1:0]                 in_valid;
  logic [NUM_IN-1:0]                 in_ready, in_ready_s;
  logic [NUM_IN-1:0][INPUT_SIZE-1:0] in_data;
  logic [NUM_IN-1:0][31:0]           in_tag;
  logic [NUM_IN-1:0][63:0]           in_serialnum;
  logic [NUM_IN-1:0]                 in_was_joined;
  logic [NUM_IN-1:0]                 in_last_processed;
  logic                              ready_4_output;
  logic [INPUT_SIZE-1:0]             out_data, out_data_s;
  logic [31:0]                       out_tag, out_tag_s;
  logic [63:0]                       out_serialnum, out_serialnum_s;
  logic                              out_was_joined, out_was_joined_s;
  logic                              out_valid, out_valid_s;
  logic                              out_last_processed, out_last_processed_s;
  logic [31:0]                       out_count, out_count_s;

  tuple_t          exp_q[$];
  int              compared = 0;
  int              mismatched = 0;
  bit              mon_en = 1'b0;

  logic [INPUT_SIZE-1:0] st_data[NUM_IN];
  logic [31:0]           st_tag[NUM_IN];
  logic [63:0]           st_serial[NUM_IN];
  logic                  st_joined[NUM_IN];

  bit              cur_valid = 1'b0, nxt_valid = 1'b0;
  bit              cur_last = 1'b0, nxt_last = 1'b0;
  longint unsigned cur_count = 0, nxt_count = 0;
  int              m_rr = 0;
  int              m_phase = P_RUN;
  bit              m_done[NUM_IN];

  always #5 clk = ~clk;

  partition_arbiter #(.INPUT_SIZE(INPUT_SIZE), .NUM_IN(NUM_IN)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_tag(in_tag), .in_serialnum(in_serialnum),
    .in_was_joined(in_was_joined), .in_last_processed(in_last_processed),
    .ready_4_output(ready_4_output), .out_data(out_data), .out_tag(out_tag),
    .out_serialnum(out_serialnum), .out_was_joined(out_was_joined),
    .out_valid(out_valid), .out_last_processed(out_last_processed),
    .out_count(out_count)
  );

  // Second copy whose counter starts just below saturation.
  partition_arbiter #(.INPUT_SIZE(INPUT_SIZE), .NUM_IN(NUM_IN), .COUNT_RESET(SAT_PRELOAD)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .in_tag(in_tag), .in_serialnum(in_serialnum),
    .in_was_joined(in_was_joined), .in_last_processed(in_last_processed),
    .ready_4_output(ready_4_output), .out_data(out_data_s), .out_tag(out_tag_s),
    .out_serialnum(out_serialnum_s), .out_was_joined(out_was_joined_s),
    .out_valid(out_valid_s), .out_last_processed(out_last_processed_s),
    .out_count(out_count_s)
  );

  function automatic logic [31:0] sat32(input longint unsigned x);
    return (x > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : x[31:0];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic setIdPayload();
    for (int i = 0; i < NUM_IN; i++) begin
      st_data[i]   = 64'hD000_0000_0000_0000 | 64'(i);
      st_tag[i]    = 32'h100 + 32'(i);
      st_serial[i] = 64'd1000 + 64'(i);
      st_joined[i] = i[0];
    end
  endtask

  task automatic randomizePayload();
    for (int i = 0; i < NUM_IN; i++) begin
      st_data[i]   = {$urandom, $urandom};
      st_tag[i]    = $urandom;
      st_serial[i] = {$urandom, $urandom};
      st_joined[i] = 1'($urandom_range(0, 1));
    end
  endtask

  // Drive one cycle of inputs at the falling edge and advance the model.
  task automatic applyStimulus(input bit rst, input logic [NUM_IN-1:0] v,
                               input logic [NUM_IN-1:0] last, input bit rdy);
    bit               ld;
    int               g;
    logic [NUM_IN-1:0] exp_rdy;
    bit               all_d;
    tuple_t           t;
    @(negedge clk);
    cur_valid = nxt_valid;
    cur_last  = nxt_last;
    cur_count = nxt_count;
    reset = rst;
    in_valid = v;
    in_last_processed = last;
    ready_4_output = rdy;
    for (int i = 0; i < NUM_IN; i++) begin
      in_data[i]       = st_data[i];
      in_tag[i]        = st_tag[i];
      in_serialnum[i]  = st_serial[i];
      in_was_joined[i] = st_joined[i];
    end
    #1;
    if (rst) begin
      checkOutput("in_ready_in_reset", 64'(in_ready), 64'd0);
      exp_q.delete();
      nxt_valid = 1'b0;
      nxt_last  = 1'b0;
      nxt_count = 0;
      m_rr      = 0;
      m_phase   = P_RUN;
      for (int i = 0; i < NUM_IN; i++) m_done[i] = 1'b0;
      return;
    end
    ld = rdy || !cur_valid;
    g = -1;
    if (ld) begin
      for (int k = 0; k < NUM_IN; k++) begin
        if (g < 0 && v[(m_rr + k) % NUM_IN]) g = (m_rr + k) % NUM_IN;
      end
    end
    exp_rdy = (g >= 0) ? (NUM_IN'(1) << g) : '0;
    checkOutput("in_ready", 64'(in_ready), 64'(exp_rdy));
    checkOutput("in_ready_sat", 64'(in_ready_s), 64'(exp_rdy));
    if (cur_valid && rdy) nxt_count = (cur_count >= 64'hFFFF_FFFF) ? cur_count : cur_count + 1;
    if (ld) begin
      if (g >= 0) begin
        t.data = st_data[g]; t.tag = st_tag[g]; t.serial = st_serial[g]; t.joined = st_joined[g];
        exp_q.push_back(t);
        nxt_valid = 1'b1;
        m_rr = (g + 1) % NUM_IN;
      end else begin
        nxt_valid = 1'b0;
      end
    end
    all_d = 1'b1;
    for (int i = 0; i < NUM_IN; i++) begin
      m_done[i] = m_done[i] | (last[i] & ~v[i]);
      all_d = all_d & m_done[i];
    end
    case (m_phase)
      P_RUN:   if (all_d && v == '0) m_phase = P_DRAIN;
      P_DRAIN: if (v != '0) m_phase = P_RUN;
               else if (!cur_valid || rdy) m_phase = P_DONE;
      default: if (v != '0) m_phase = P_RUN;
    endcase
    nxt_last = (m_phase == P_DONE);
  endtask

  // Monitor: samples just before each rising edge and pops on transfers.
  initial begin
    tuple_t t;
    forever begin
      @(negedge clk);
      #4;
      if (mon_en) begin
        checkOutput("out_valid", 64'(out_valid), 64'(cur_valid));
        checkOutput("out_valid_sat", 64'(out_valid_s), 64'(cur_valid));
        checkOutput("out_last_processed", 64'(out_last_processed), 64'(cur_last));
        checkOutput("out_last_processed_sat", 64'(out_last_processed_s), 64'(cur_last));
        checkOutput("out_count", 64'(out_count), 64'(sat32(cur_count)));
        checkOutput("out_count_sat", 64'(out_count_s), 64'(sat32(cur_count + 64'(SAT_PRELOAD))));
        if (!reset) begin
          if (!out_valid) begin
            t = '0;
          end else if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL scoreboard_empty: got out_valid=1, expected no pending tuple at %0t", $time);
            t = '0;
          end else begin
            t = exp_q[0];
          end
          checkOutput("out_data", out_data, t.data);
          checkOutput("out_tag", 64'(out_tag), 64'(t.tag));
          checkOutput("out_serialnum", out_serialnum, t.serial);
          checkOutput("out_was_joined", 64'(out_was_joined), 64'(t.joined));
          checkOutput("out_tag_sat", 64'(out_tag_s), 64'(t.tag));
          checkOutput("out_data_sat", out_data_s, t.data);
          if (out_valid && ready_4_output && exp_q.size() != 0) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [NUM_IN-1:0] v, last;
    reset = 1'b1;
    in_valid = '0;
    in_last_processed = '0;
    ready_4_output = 1'b0;
    in_data = '0;
    in_tag = '0;
    in_serialnum = '0;
    in_was_joined = '0;
    for (int i = 0; i < NUM_IN; i++) m_done[i] = 1'b0;
    setIdPayload();
    applyStimulus(1'b1, '0, '0, 1'b0);
    mon_en = 1'b1;
    applyStimulus(1'b1, '0, '0, 1'b0);

    // All streams valid for eight cycles: strict rotation.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 4'hF, '0, 1'b1);
      checkOutput("grant_order", 64'(in_ready), 64'(4'b0001 << (k % 4)));
    end
    applyStimulus(1'b0, '0, '0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b1);
    checkOutput("count_after_8", 64'(out_count), 64'd8);
    checkOutput("count_saturated", 64'(out_count_s), 64'hFFFF_FFFF);

    // Single stream 2 with a known tag and serial number.
    st_tag[2] = 32'hA5;
    st_serial[2] = 64'd7;
    applyStimulus(1'b0, 4'b0100, '0, 1'b1);
    checkOutput("stream2_ready", 64'(in_ready), 64'b0100);
    applyStimulus(1'b0, '0, '0, 1'b1);
    checkOutput("stream2_valid", 64'(out_valid), 64'd1);
    checkOutput("stream2_tag", 64'(out_tag), 64'hA5);
    checkOutput("stream2_serial", out_serialnum, 64'd7);

    // Backpressure: a tuple from stream 3 held for five stalled cycles.
    setIdPayload();
    applyStimulus(1'b0, 4'hF, '0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 4'hF, '0, 1'b0);
      checkOutput("stall_ready", 64'(in_ready), 64'd0);
      checkOutput("stall_tag", 64'(out_tag), 64'h103);
    end
    applyStimulus(1'b0, '0, '0, 1'b1);

    // End of stream while a tuple is held, then drain.
    applyStimulus(1'b0, 4'b0001, '0, 1'b1);
    applyStimulus(1'b0, '0, 4'hF, 1'b0);
    applyStimulus(1'b0, '0, 4'hF, 1'b0);
    checkOutput("drain_last", 64'(out_last_processed), 64'd0);
    checkOutput("drain_valid", 64'(out_valid), 64'd1);
    applyStimulus(1'b0, '0, '0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0);
    checkOutput("done_last", 64'(out_last_processed), 64'd1);
    checkOutput("done_valid", 64'(out_valid), 64'd0);

    // Reset from DONE; arbitration restarts at stream 0.
    applyStimulus(1'b1, 4'hF, '0, 1'b0);
    applyStimulus(1'b0, 4'hF, '0, 1'b1);
    checkOutput("post_reset_last", 64'(out_last_processed), 64'd0);
    checkOutput("post_reset_count", 64'(out_count), 64'd0);
    checkOutput("post_reset_ready", 64'(in_ready), 64'b0001);

    for (int n = 0; n < 3000; n++) begin
      randomizePayload();
      for (int i = 0; i < NUM_IN; i++) begin
        v[i]    = ($urandom_range(0, 9) < 5);
        last[i] = ($urandom_range(0, 19) == 0);
      end
      applyStimulus($urandom_range(0, 299) == 0, v, last, $urandom_range(0, 9) < 7);
    end
    applyStimulus(1'b0, '0, '0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b1);
    @(negedge clk);
    #6;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
